// File: rtl/dcache_bank_arb.sv
// Per-bank arbiter between the L1 dcache requesters and the banked tag/data SRAM ways.
// Port 0 (miss handler) always wins its bank. Other ports use fixed or round-robin priority with starvation escalation.
module dcache_bank_arb #(
  parameter int NumPorts    = 5,
  parameter int NumBanks    = 2,
  parameter int AddrWidth   = 12,
  parameter int DataWidth   = 128,
  parameter int Assoc       = 8,
  parameter int BankSelLsb  = 4,
  parameter int RrMode      = 1,
  parameter int StarveLimit = 15
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NumPorts*Assoc-1:0]              req_i,
  input  logic [NumPorts*AddrWidth-1:0]          addr_i,
  input  logic [NumPorts-1:0]                    we_i,
  input  logic [NumPorts*DataWidth-1:0]          wdata_i,
  input  logic [NumPorts*(DataWidth/8)-1:0]      be_i,
  output logic [NumPorts-1:0]                    gnt_o,
  output logic [NumPorts-1:0]                    rvalid_o,
  output logic [NumPorts*Assoc*DataWidth-1:0]    rdata_o,
  output logic [NumBanks*Assoc-1:0]              bank_req_o,
  output logic [NumBanks*AddrWidth-1:0]          bank_addr_o,
  output logic [NumBanks-1:0]                    bank_we_o,
  output logic [NumBanks*DataWidth-1:0]          bank_wdata_o,
  output logic [NumBanks*(DataWidth/8)-1:0]      bank_be_o,
  input  logic [NumBanks*Assoc*DataWidth-1:0]    bank_rdata_i,
  output logic                                   busy_o
);

  localparam int BankW = (NumBanks > 1) ? $clog2(NumBanks) : 1;
  localparam int PortW = $clog2(NumPorts);
  localparam int CntW  = (StarveLimit > 0) ? $clog2(StarveLimit + 1) : 1;
  localparam int BeW   = DataWidth / 8;
  localparam int LineW = Assoc * DataWidth;

  logic [NumPorts-1:0] req_any;
  logic [BankW-1:0]    port_bank [NumPorts];
  logic [NumPorts-1:0] cand      [NumBanks];
  logic [NumBanks-1:0] win_valid;
  logic [NumBanks-1:0] win_rr;
  logic [PortW-1:0]    win_idx   [NumBanks];
  logic [PortW-1:0]    ptr_q     [NumBanks];
  logic [PortW-1:0]    ptr_d     [NumBanks];
  logic [CntW-1:0]     cnt_q     [NumPorts];
  logic [CntW-1:0]     cnt_d     [NumPorts];
  logic [NumBanks-1:0] rv_valid_q;
  logic [NumBanks-1:0] rv_valid_d;
  logic [PortW-1:0]    rv_port_q [NumBanks];
  logic [PortW-1:0]    rv_port_d [NumBanks];

  // Reset masks every request, which forces all grant-side outputs to zero.
  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      req_any[p]   = !rst_i && (req_i[p*Assoc +: Assoc] != '0);
      port_bank[p] = (NumBanks > 1) ? addr_i[p*AddrWidth + BankSelLsb +: BankW] : '0;
    end
    for (int b = 0; b < NumBanks; b++) begin
      for (int p = 0; p < NumPorts; p++) begin
        cand[b][p] = req_any[p] && (port_bank[p] == BankW'(b));
      end
    end
  end

  always_comb begin
    int sel;
    sel = 0;
    for (int b = 0; b < NumBanks; b++) begin
      win_valid[b] = 1'b0;
      win_rr[b]    = 1'b0;
      win_idx[b]   = '0;
      if (cand[b][0]) begin
        win_valid[b] = 1'b1;
      end
      if (StarveLimit != 0) begin
        for (int p = 0; p < NumPorts; p++) begin
          if (!win_valid[b] && cand[b][p] && (cnt_q[p] == CntW'(StarveLimit))) begin
            win_valid[b] = 1'b1;
            win_idx[b]   = PortW'(p);
          end
        end
      end
      // The round-robin scan starts at the bank pointer and wraps within ports 1..NumPorts-1.
      if (RrMode != 0) begin
        for (int k = 0; k < NumPorts - 1; k++) begin
          sel = int'(ptr_q[b]) + k;
          if (sel >= NumPorts) sel = sel - (NumPorts - 1);
          if (!win_valid[b] && cand[b][sel]) begin
            win_valid[b] = 1'b1;
            win_rr[b]    = 1'b1;
            win_idx[b]   = PortW'(sel);
          end
        end
      end else begin
        for (int p = 1; p < NumPorts; p++) begin
          if (!win_valid[b] && cand[b][p]) begin
            win_valid[b] = 1'b1;
            win_idx[b]   = PortW'(p);
          end
        end
      end
    end
  end

  always_comb begin
    int w;
    w            = 0;
    gnt_o        = '0;
    bank_req_o   = '0;
    bank_addr_o  = '0;
    bank_we_o    = '0;
    bank_wdata_o = '0;
    bank_be_o    = '0;
    rv_valid_d   = '0;
    for (int b = 0; b < NumBanks; b++) begin
      rv_port_d[b] = win_idx[b];
      ptr_d[b]     = ptr_q[b];
      if (win_valid[b]) begin
        w = int'(win_idx[b]);
        gnt_o[w]                              = 1'b1;
        bank_req_o[b*Assoc +: Assoc]          = req_i[w*Assoc +: Assoc];
        bank_addr_o[b*AddrWidth +: AddrWidth] = addr_i[w*AddrWidth +: AddrWidth];
        bank_we_o[b]                          = we_i[w];
        bank_wdata_o[b*DataWidth +: DataWidth] = wdata_i[w*DataWidth +: DataWidth];
        bank_be_o[b*BeW +: BeW]               = be_i[w*BeW +: BeW];
        rv_valid_d[b]                         = !we_i[w];
        if (win_rr[b]) begin
          ptr_d[b] = (w == NumPorts - 1) ? PortW'(1) : PortW'(w + 1);
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      cnt_d[p] = cnt_q[p];
      if (p == 0 || !req_any[p] || gnt_o[p]) begin
        cnt_d[p] = '0;
      end else if (cnt_q[p] != CntW'(StarveLimit)) begin
        cnt_d[p] = cnt_q[p] + CntW'(1);
      end
    end
  end

  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    for (int b = 0; b < NumBanks; b++) begin
      if (!rst_i && rv_valid_q[b]) begin
        rvalid_o[rv_port_q[b]] = 1'b1;
        rdata_o[int'(rv_port_q[b])*LineW +: LineW] = bank_rdata_i[b*LineW +: LineW];
      end
    end
  end

  assign busy_o = (|req_any) | (!rst_i && (|rv_valid_q));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rv_valid_q <= '0;
      for (int b = 0; b < NumBanks; b++) begin
        ptr_q[b]     <= PortW'(1);
        rv_port_q[b] <= '0;
      end
      for (int p = 0; p < NumPorts; p++) begin
        cnt_q[p] <= '0;
      end
    end else begin
      rv_valid_q <= rv_valid_d;
      for (int b = 0; b < NumBanks; b++) begin
        ptr_q[b]     <= ptr_d[b];
        rv_port_q[b] <= rv_port_d[b];
      end
      for (int p = 0; p < NumPorts; p++) begin
        cnt_q[p] <= cnt_d[p];
      end
    end
  end

endmodule

// File: tb/tb_dcache_bank_arb.sv
// Bench for dcache_bank_arb: a round-robin instance (limit 15) and a fixed-priority instance (limit 3).
// Both instances share stimulus and are checked every cycle against a behavioural model.
module tb_dcache_bank_arb;

  localparam int NP  = 5;
  localparam int NB  = 2;
  localparam int AW  = 12;
  localparam int DW  = 128;
  localparam int AS  = 8;
  localparam int BEW = DW / 8;
  localparam int LW  = AS * DW;
  localparam int BSL = 4;

  typedef struct {
    logic [NP-1:0] req;
    logic [NP-1:0] bank;
    logic [NP-1:0] we;
    logic [NP-1:0] gnt_a;
    logic [NP-1:0] gnt_b;
    logic [NP-1:0] rv_a;
  } vec_t;

  logic clk;
  logic rst;
  logic [NP*AS-1:0]  req;
  logic [NP*AW-1:0]  addr;
  logic [NP-1:0]     we;
  logic [NP*DW-1:0]  wdata;
  logic [NP*BEW-1:0] be;
  logic [NB*LW-1:0]  brdata;

  logic [NP-1:0]     d_gnt    [2];
  logic [NP-1:0]     d_rvalid [2];
  logic [NP*LW-1:0]  d_rdata  [2];
  logic [NB*AS-1:0]  d_breq   [2];
  logic [NB*AW-1:0]  d_baddr  [2];
  logic [NB-1:0]     d_bwe    [2];
  logic [NB*DW-1:0]  d_bwdata [2];
  logic [NB*BEW-1:0] d_bbe    [2];
  logic [1:0]        d_busy;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  int lim [2] = '{15, 3};
  bit rrm [2] = '{1'b1, 1'b0};
  int m_ptr      [2][NB];
  int m_cnt      [2][NP];
  bit m_rv_valid [2][NB];
  int m_rv_port  [2][NB];
  int m_win      [2][NB];
  bit m_rr       [2][NB];
  logic [NP-1:0] m_gnt0;

  vec_t tbl [16];

  dcache_bank_arb u_dut_rr (
    .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .we_i(we), .wdata_i(wdata), .be_i(be),
    .gnt_o(d_gnt[0]), .rvalid_o(d_rvalid[0]), .rdata_o(d_rdata[0]), .bank_req_o(d_breq[0]),
    .bank_addr_o(d_baddr[0]), .bank_we_o(d_bwe[0]), .bank_wdata_o(d_bwdata[0]), .bank_be_o(d_bbe[0]),
    .bank_rdata_i(brdata), .busy_o(d_busy[0])
  );

  dcache_bank_arb #(.RrMode(0), .StarveLimit(3)) u_dut_fp (
    .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .we_i(we), .wdata_i(wdata), .be_i(be),
    .gnt_o(d_gnt[1]), .rvalid_o(d_rvalid[1]), .rdata_o(d_rdata[1]), .bank_req_o(d_breq[1]),
    .bank_addr_o(d_baddr[1]), .bank_we_o(d_bwe[1]), .bank_wdata_o(d_bwdata[1]), .bank_be_o(d_bbe[1]),
    .bank_rdata_i(brdata), .busy_o(d_busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input int inst, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s dut%0d cycle %0d: got %h, want %h", name, inst, cycle, act, exp);
    end
  endtask

  function automatic bit requesting(input int p);
    return !rst && (req[p*AS +: AS] != '0);
  endfunction

  function automatic bit cand(input int p, input int b);
    return requesting(p) && (((int'(addr[p*AW +: AW]) >> BSL) % NB) == b);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      for (int b = 0; b < NB; b++) begin
        m_ptr[i][b] = 1; m_rv_valid[i][b] = 1'b0; m_rv_port[i][b] = 0; m_win[i][b] = -1;
      end
      for (int p = 0; p < NP; p++) m_cnt[i][p] = 0;
    end
    m_gnt0 = '0;
  endtask

  // Winner per bank: miss handler, then escalated ports, then rotating or fixed order.
  task automatic checkOutput();
    logic [NP-1:0]  e_gnt, e_rv;
    logic [NP*LW-1:0] e_rdata;
    logic [AS-1:0]  e_req;
    logic [AW-1:0]  e_addr;
    logic [DW-1:0]  e_wd;
    logic [BEW-1:0] e_be;
    logic           e_we, e_busy;
    int w, q;
    bit rr;
    for (int i = 0; i < 2; i++) begin
      e_gnt = '0; e_rv = '0; e_rdata = '0; e_busy = 1'b0;
      for (int p = 0; p < NP; p++) if (requesting(p)) e_busy = 1'b1;
      for (int b = 0; b < NB; b++) begin
        w = -1; rr = 1'b0;
        if (!rst) begin
          if (cand(0, b)) w = 0;
          for (int p = 1; p < NP; p++)
            if (w < 0 && lim[i] > 0 && cand(p, b) && m_cnt[i][p] == lim[i]) w = p;
          for (int k = 0; k < NP - 1; k++) begin
            q = ((m_ptr[i][b] - 1 + k) % (NP - 1)) + 1;
            if (w < 0 && rrm[i] && cand(q, b)) begin w = q; rr = 1'b1; end
          end
          for (int p = 1; p < NP; p++) if (w < 0 && !rrm[i] && cand(p, b)) w = p;
        end
        m_win[i][b] = w; m_rr[i][b] = rr;
        e_req = '0; e_addr = '0; e_wd = '0; e_be = '0; e_we = 1'b0;
        if (w >= 0) begin
          e_gnt[w] = 1'b1;
          e_req = req[w*AS +: AS]; e_addr = addr[w*AW +: AW]; e_we = we[w];
          e_wd = wdata[w*DW +: DW]; e_be = be[w*BEW +: BEW];
        end
        cmp("bank_req", i, d_breq[i][b*AS +: AS], e_req);
        cmp("bank_addr", i, d_baddr[i][b*AW +: AW], e_addr);
        cmp("bank_we", i, d_bwe[i][b], e_we);
        cmp("bank_wdata", i, d_bwdata[i][b*DW +: DW], e_wd);
        cmp("bank_be", i, d_bbe[i][b*BEW +: BEW], e_be);
        if (!rst && m_rv_valid[i][b]) begin
          e_rv[m_rv_port[i][b]] = 1'b1;
          e_rdata[m_rv_port[i][b]*LW +: LW] = brdata[b*LW +: LW];
          e_busy = 1'b1;
        end
      end
      if (i == 0) m_gnt0 = e_gnt;
      cmp("gnt", i, d_gnt[i], e_gnt);
      cmp("rvalid", i, d_rvalid[i], e_rv);
      cmp("busy", i, d_busy[i], e_busy);
      for (int p = 0; p < NP; p++)
        for (int y = 0; y < AS; y++)
          cmp($sformatf("rdata_p%0d_w%0d", p, y), i, d_rdata[i][p*LW + y*DW +: DW], e_rdata[p*LW + y*DW +: DW]);
    end
  endtask

  task automatic updateModel();
    bit granted;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        for (int b = 0; b < NB; b++) begin m_ptr[i][b] = 1; m_rv_valid[i][b] = 1'b0; end
        for (int p = 0; p < NP; p++) m_cnt[i][p] = 0;
      end else begin
        for (int b = 0; b < NB; b++) begin
          m_rv_valid[i][b] = (m_win[i][b] >= 0) && !we[m_win[i][b]];
          if (m_win[i][b] >= 0) m_rv_port[i][b] = m_win[i][b];
          if (m_win[i][b] >= 0 && m_rr[i][b]) m_ptr[i][b] = (m_win[i][b] == NP - 1) ? 1 : m_win[i][b] + 1;
        end
        for (int p = 1; p < NP; p++) begin
          granted = 1'b0;
          for (int b = 0; b < NB; b++) if (m_win[i][b] == p) granted = 1'b1;
          if (!requesting(p) || granted) m_cnt[i][p] = 0;
          else if (m_cnt[i][p] < lim[i]) m_cnt[i][p]++;
        end
      end
    end
  endtask

  task automatic settle();
    for (int j = 0; j < NB * LW / 32; j++) brdata[j*32 +: 32] = $urandom;
    @(negedge clk);
    checkOutput();
  endtask

  task automatic advance();
    @(posedge clk);
    updateModel();
    cycle++;
    #1;
  endtask

  task automatic setPort(input int p, input bit on, input bit bank, input bit wr, input logic [BEW-1:0] bev);
    req[p*AS +: AS]   = on ? (8'h80 | 8'(p + 1)) : 8'h00;
    addr[p*AW +: AW]  = 12'(p * 256 + 5) | (bank ? 12'h010 : 12'h000);
    we[p]             = wr;
    wdata[p*DW +: DW] = {4{32'hC0DE_0000 | 32'(p)}};
    be[p*BEW +: BEW]  = bev;
  endtask

  task automatic applyStimulus(input vec_t v);
    rst = 1'b0;
    for (int p = 0; p < NP; p++) setPort(p, v.req[p], v.bank[p], v.we[p], 16'hFFFF);
  endtask

  task automatic randomStimulus(input bit heavy0);
    bit on;
    rst = ($urandom_range(0, 59) == 0);
    for (int p = 0; p < NP; p++) begin
      if (req[p*AS +: AS] != '0 && !m_gnt0[p] && $urandom_range(0, 9) < 8) continue;
      on = (heavy0 && p == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 6);
      req[p*AS +: AS]  = on ? 8'($urandom_range(1, 255)) : 8'h00;
      addr[p*AW +: AW] = 12'($urandom);
      if (heavy0) addr[p*AW + BSL] = 1'b0;
      we[p]            = 1'($urandom);
      for (int j = 0; j < DW / 32; j++) wdata[p*DW + j*32 +: 32] = $urandom;
      be[p*BEW +: BEW] = 16'($urandom);
    end
  endtask

  initial begin
    //          req       bank      we        gnt_a     gnt_b     rv_a
    tbl[0]  = '{5'b11110, 5'b00000, 5'b00000, 5'b00010, 5'b00010, 5'b00000};
    tbl[1]  = '{5'b11110, 5'b00000, 5'b00000, 5'b00100, 5'b00010, 5'b00010};
    tbl[2]  = '{5'b11110, 5'b00000, 5'b00000, 5'b01000, 5'b00010, 5'b00100};
    tbl[3]  = '{5'b11110, 5'b00000, 5'b00000, 5'b10000, 5'b00100, 5'b01000};
    tbl[4]  = '{5'b11110, 5'b00000, 5'b00000, 5'b00010, 5'b01000, 5'b10000};
    tbl[5]  = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00010};
    tbl[6]  = '{5'b00110, 5'b00100, 5'b00000, 5'b00110, 5'b00110, 5'b00000};
    tbl[7]  = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00110};
    tbl[8]  = '{5'b01011, 5'b00000, 5'b01011, 5'b00001, 5'b00001, 5'b00000};
    tbl[9]  = '{5'b01010, 5'b00000, 5'b00000, 5'b01000, 5'b00010, 5'b00000};
    tbl[10] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b01000};
    tbl[11] = '{5'b00110, 5'b00000, 5'b00000, 5'b00010, 5'b00010, 5'b00000};
    tbl[12] = '{5'b00110, 5'b00000, 5'b00000, 5'b00100, 5'b00010, 5'b00010};
    tbl[13] = '{5'b00110, 5'b00000, 5'b00000, 5'b00010, 5'b00010, 5'b00100};
    tbl[14] = '{5'b00110, 5'b00000, 5'b00000, 5'b00100, 5'b00100, 5'b00010};
    tbl[15] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00100};

    rst = 1'b1; req = '0; addr = '0; we = '0; wdata = '0; be = '0; brdata = '0;
    modelReset();
    for (int c = 0; c < 3; c++) begin
      settle();
      cmp("reset_gnt", 0, d_gnt[0], '0);
      cmp("reset_busy", 1, d_busy[1], 1'b0);
      advance();
    end

    $display("[TB] directed vector table");
    for (int v = 0; v < 16; v++) begin
      applyStimulus(tbl[v]);
      settle();
      cmp($sformatf("tbl%0d_gnt", v), 0, d_gnt[0], tbl[v].gnt_a);
      cmp($sformatf("tbl%0d_gnt", v), 1, d_gnt[1], tbl[v].gnt_b);
      cmp($sformatf("tbl%0d_rvalid", v), 0, d_rvalid[0], tbl[v].rv_a);
      advance();
    end

    $display("[TB] write then read on port 2");
    setPort(2, 1'b1, 1'b0, 1'b1, 16'h000F);
    settle();
    cmp("wr_gnt", 0, d_gnt[0], 5'b00100);
    cmp("wr_be", 0, d_bbe[0][0 +: BEW], 16'h000F);
    cmp("wr_we", 0, d_bwe[0][0], 1'b1);
    advance();
    setPort(2, 1'b1, 1'b0, 1'b0, 16'hFFFF);
    settle();
    cmp("rd_gnt", 0, d_gnt[0], 5'b00100);
    cmp("rd_no_rvalid_after_write", 0, d_rvalid[0], 5'b00000);
    advance();
    setPort(2, 1'b0, 1'b0, 1'b0, 16'hFFFF);
    settle();
    cmp("rd_rvalid", 0, d_rvalid[0], 5'b00100);
    cmp("rd_data", 0, d_rdata[0][2*LW +: DW], brdata[0 +: DW]);
    advance();

    $display("[TB] reset during a read grant");
    setPort(1, 1'b1, 1'b0, 1'b0, 16'hFFFF);
    settle();
    cmp("pre_reset_gnt", 0, d_gnt[0], 5'b00010);
    advance();
    rst = 1'b1;
    setPort(2, 1'b1, 1'b1, 1'b0, 16'hFFFF);
    settle();
    cmp("in_reset_gnt", 0, d_gnt[0], 5'b00000);
    cmp("in_reset_rvalid", 0, d_rvalid[0], 5'b00000);
    cmp("in_reset_bank_req", 0, d_breq[0], '0);
    cmp("in_reset_busy", 0, d_busy[0], 1'b0);
    advance();
    rst = 1'b0;
    setPort(1, 1'b0, 1'b0, 1'b0, 16'hFFFF);
    setPort(2, 1'b0, 1'b0, 1'b0, 16'hFFFF);
    settle();
    cmp("post_reset_rvalid", 0, d_rvalid[0], 5'b00000);
    cmp("post_reset_busy", 0, d_busy[0], 1'b0);
    advance();
    for (int p = 1; p < NP; p++) setPort(p, 1'b1, 1'b0, 1'b0, 16'hFFFF);
    settle();
    cmp("post_reset_rr_first", 0, d_gnt[0], 5'b00010);
    advance();

    $display("[TB] random traffic");
    for (int c = 0; c < 250; c++) begin
      randomStimulus(1'b0);
      settle();
      advance();
    end
    for (int c = 0; c < 250; c++) begin
      randomStimulus(1'b1);
      settle();
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
